// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point packet accumulator.
// Holds the FSM state enum, the Q-format sanity check and the saturation bounds.
package fxp_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    function automatic bit qformat_ok(input int width, input int int_width,
                                      input int frac_width, input int max_len);
        return (width == int_width + frac_width) && (max_len >= 1) && (width >= 2);
    endfunction

    // Most positive / most negative value representable in a signed word of 'width' bits.
    function automatic logic signed [63:0] sat_bound(input int width, input logic negative);
        if (negative)
            return -(64'sd1 <<< (width - 1));
        else
            return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational signed WIDTH-bit adder with overflow detect.
// Clamps on overflow when FXP_ACC_SATURATE_EN is defined, otherwise wraps modulo 2^WIDTH.
module fxp_sat_add
    import fxp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    overflow
);

`ifdef FXP_ACC_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(sat_bound(WIDTH, 1'b0));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(sat_bound(WIDTH, 1'b1));
`endif

    logic [WIDTH:0] wide;

    // One guard bit: overflow whenever the guard and the word's sign bit disagree.
    always_comb begin
        wide     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        overflow = wide[WIDTH] ^ wide[WIDTH-1];
`ifdef FXP_ACC_SATURATE_EN
        if (overflow)
            sum = wide[WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sum = wide[WIDTH-1:0];
`else
        sum = wide[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/fxp_accumulator.sv
// Packet accumulator: sums signed Q(INTEGERWIDTH).(FRACTIONWIDTH) beats up to in_last or MAXLEN terms.
// Build option FXP_ACC_SATURATE_EN selects saturating instead of wrapping steps.
module fxp_accumulator
    import fxp_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int INTEGERWIDTH  = 4,
    parameter int FRACTIONWIDTH = 4,
    parameter int MAXLEN        = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [WIDTH-1:0]          in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [WIDTH-1:0]          out_data,
    output logic [$clog2(MAXLEN+1)-1:0]      out_count,
    output logic                             out_overflow
);

    localparam int CNTW = $clog2(MAXLEN + 1);
    localparam logic [CNTW-1:0] MAX_COUNT = CNTW'(MAXLEN);

    if (!qformat_ok(WIDTH, INTEGERWIDTH, FRACTIONWIDTH, MAXLEN)) begin : g_cfg_error
        $error("fxp_accumulator: need WIDTH == INTEGERWIDTH + FRACTIONWIDTH and MAXLEN >= 1");
    end

    state_t                  state, state_next;
    logic signed [WIDTH-1:0] acc;
    logic [CNTW-1:0]         count;
    logic                    ovf;

    logic                    accept;
    logic [CNTW-1:0]         count_next;
    logic signed [WIDTH-1:0] add_a;
    logic signed [WIDTH-1:0] step_sum;
    logic                    step_ovf;

    assign accept     = in_valid && (state == S_ACC);
    assign count_next = count + CNTW'(1);
    // The first term loads rather than adds; adding to zero can never overflow.
    assign add_a      = (count == '0) ? '0 : acc;

    fxp_sat_add #(
        .WIDTH(WIDTH)
    ) u_add (
        .a       (add_a),
        .b       (in_data),
        .sum     (step_sum),
        .overflow(step_ovf)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (accept && (in_last || count_next == MAX_COUNT))
                    state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = S_ACC;
            end
            default: state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_ACC;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc   <= step_sum;
                count <= count_next;
                ovf   <= ovf | step_ovf;
            end else if (state == S_OUT && out_ready) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end

    assign out_data     = acc;
    assign out_count    = count;
    assign out_overflow = ovf;

endmodule

// File: tb/tb_fxp_accumulator.sv
// Self-checking bench for fxp_accumulator: directed corner cases plus randomized packets
// compared against an integer-arithmetic reference model (honours FXP_ACC_SATURATE_EN).
module tb_fxp_accumulator;

    localparam int WIDTH  = 8;
    localparam int MAXLEN = 16;
    localparam int CNTW   = $clog2(MAXLEN + 1);
    localparam int MAXV   = 127;
    localparam int MINV   = -128;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic [CNTW-1:0]         out_count;
    logic                    out_overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_acc;
    int m_cnt;
    bit m_ovf;

    fxp_accumulator #(
        .WIDTH(WIDTH), .INTEGERWIDTH(4), .FRACTIONWIDTH(4), .MAXLEN(MAXLEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic void model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    // Returns 1 when this beat closes the packet.
    function automatic bit model_beat(input logic [7:0] d, input bit last);
        int v;
        int s;
        v = (d > 8'd127) ? int'(d) - 256 : int'(d);
        s = (m_cnt == 0) ? v : m_acc + v;
        if (s > MAXV || s < MINV) begin
            m_ovf = 1'b1;
`ifdef FXP_ACC_SATURATE_EN
            s = (s > MAXV) ? MAXV : MINV;
`else
            s = ((s - MINV) % 256 + 256) % 256 + MINV;
`endif
        end
        m_acc = s;
        m_cnt = m_cnt + 1;
        return last || (m_cnt == MAXLEN);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_compared++; if (out_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        n_compared++; if (out_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count); end
        n_compared++; if (out_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_overflow: got %b expected 0", out_overflow); end
    endtask

    task automatic test_basic_sum();
        send_beat(8'h18, 1'b0);
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_mid_valid: got %b expected 0", out_valid); end
        send_beat(8'h24, 1'b1);
        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_latency: got %b expected 1", out_valid); end
        n_compared++; if (out_data !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL basic_data: got %h expected 3c", out_data); end
        n_compared++; if (out_count !== 5'd2) begin n_mismatched++; $display("[TB] FAIL basic_count: got %0d expected 2", out_count); end
        n_compared++; if (out_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_overflow: got %b expected 0", out_overflow); end
        take_result();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pos;
        logic [7:0] exp_neg;
`ifdef FXP_ACC_SATURATE_EN
        exp_pos = 8'h7F;
        exp_neg = 8'h80;
`else
        exp_pos = 8'h90;
        exp_neg = 8'h7F;
`endif
        send_beat(8'h70, 1'b0);
        send_beat(8'h20, 1'b1);
        n_compared++; if (out_data !== exp_pos) begin n_mismatched++; $display("[TB] FAIL pos_ovf_data: got %h expected %h", out_data, exp_pos); end
        n_compared++; if (out_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pos_ovf_flag: got %b expected 1", out_overflow); end
        take_result();
        send_beat(8'h80, 1'b0);
        send_beat(8'hFF, 1'b1);
        n_compared++; if (out_data !== exp_neg) begin n_mismatched++; $display("[TB] FAIL neg_ovf_data: got %h expected %h", out_data, exp_neg); end
        n_compared++; if (out_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL neg_ovf_flag: got %b expected 1", out_overflow); end
        take_result();
        // Sticky flag must not leak into the next packet.
        send_beat(8'h01, 1'b1);
        n_compared++; if (out_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_cleared: got %b expected 0", out_overflow); end
        take_result();
    endtask

    task automatic test_backpressure();
        send_beat(8'h11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            in_last  = 1'($urandom_range(0, 1));
            tick();
            n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
            n_compared++; if (out_data !== 8'h11 || out_count !== 5'd1) begin n_mismatched++; $display("[TB] FAIL hold_data[%0d]: got %h/%0d expected 11/1", i, out_data, out_count); end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result();
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL release_out_valid: got %b expected 0", out_valid); end
        send_beat(8'h02, 1'b1);
        n_compared++; if (out_data !== 8'h02 || out_count !== 5'd1) begin n_mismatched++; $display("[TB] FAIL after_hold: got %h/%0d expected 02/1", out_data, out_count); end
        take_result();
    endtask

    task automatic test_maxlen();
        for (int i = 0; i < MAXLEN; i++) begin
            n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL maxlen_early[%0d]: got %b expected 0", i, out_valid); end
            send_beat(8'h01, 1'b0);
        end
        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL maxlen_valid: got %b expected 1", out_valid); end
        n_compared++; if (out_data !== 8'h10) begin n_mismatched++; $display("[TB] FAIL maxlen_data: got %h expected 10", out_data); end
        n_compared++; if (out_count !== 5'd16) begin n_mismatched++; $display("[TB] FAIL maxlen_count: got %0d expected 16", out_count); end
        take_result();
        send_beat(8'h03, 1'b1);
        n_compared++; if (out_data !== 8'h03 || out_count !== 5'd1) begin n_mismatched++; $display("[TB] FAIL maxlen_next: got %h/%0d expected 03/1", out_data, out_count); end
        take_result();
    endtask

    task automatic test_mid_reset();
        send_beat(8'h07, 1'b0);
        send_beat(8'h09, 1'b0);
        send_beat(8'h0B, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_compared++; if (out_valid !== 1'b0 || out_count !== 5'd0) begin n_mismatched++; $display("[TB] FAIL midpkt_reset[%0d]: got valid %b count %0d expected 0/0", i, out_valid, out_count); end
            tick();
        end
        send_beat(8'h05, 1'b1);
        n_compared++; if (out_data !== 8'h05 || out_count !== 5'd1) begin n_mismatched++; $display("[TB] FAIL post_reset_pkt: got %h/%0d expected 05/1", out_data, out_count); end
        // Reset while a result is pending drops it.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_compared++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL out_reset: got valid %b data %h expected 0/00", out_valid, out_data); end
    endtask

    task automatic test_random();
        bit done;
        int len;
        logic [7:0] d;
        model_reset();
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                d = 8'($urandom_range(0, 255));
                send_beat(d, i == len - 1);
                done = model_beat(d, i == len - 1);
                if (done) begin
                    for (int w = 0; w <= int'($urandom_range(0, 3)); w++) begin
                        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rand_valid p%0d: got %b expected 1", p, out_valid); end
                        n_compared++; if (out_data !== 8'(m_acc)) begin n_mismatched++; $display("[TB] FAIL rand_data p%0d: got %h expected %h", p, out_data, 8'(m_acc)); end
                        n_compared++; if (out_count !== 5'(m_cnt)) begin n_mismatched++; $display("[TB] FAIL rand_count p%0d: got %0d expected %0d", p, out_count, m_cnt); end
                        n_compared++; if (out_overflow !== m_ovf) begin n_mismatched++; $display("[TB] FAIL rand_ovf p%0d: got %b expected %b", p, out_overflow, m_ovf); end
                        if (w < 3) tick();
                    end
                    take_result();
                    model_reset();
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_overflow();
        test_backpressure();
        test_maxlen();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fxp_accumulator.md
FXP_ACCUMULATOR -- requirements
Module: fxp_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, total signed fixed-point word width.
REQ-002 SHALL have parameter INTEGERWIDTH, default 4, integer bits including sign.
REQ-003 SHALL have parameter FRACTIONWIDTH, default 4, fraction bits.
REQ-004 SHALL have parameter MAXLEN, default 16, maximum terms per packet; CNTW = clog2(MAXLEN+1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, input beat valid.
REQ-008 SHALL have port in_ready, output, 1, accumulator can accept a beat.
REQ-009 SHALL have port in_data, input, WIDTH signed, Q(INTEGERWIDTH).(FRACTIONWIDTH) operand.
REQ-010 SHALL have port in_last, input, 1, final term of packet.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port out_data, output, WIDTH signed, packet sum.
REQ-014 SHALL have port out_count, output, CNTW, number of terms summed.
REQ-015 SHALL have port out_overflow, output, 1, sticky: any step of this packet overflowed.

Function
REQ-016 SHALL implement two states: S_ACC (in_ready=1, out_valid=0) and S_OUT (in_ready=0, out_valid=1).
REQ-017 SHALL accept a beat in S_ACC when in_valid && in_ready; first beat loads acc=in_data, later beats acc=acc+in_data.
REQ-018 SHALL compute each step at WIDTH+1 bits and flag overflow when the result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 SHALL increment the count per accepted beat and OR each step's overflow into the sticky flag.
REQ-020 SHALL move S_ACC->S_OUT on an accepted beat with in_last=1 or with count reaching MAXLEN; out_valid asserts the next cycle (latency 1).
REQ-021 SHALL hold out_data, out_count, out_overflow stable while out_valid && !out_ready.
REQ-022 SHALL on out_valid && out_ready clear acc, count and the overflow flag, and return to S_ACC the next cycle.
REQ-023 SHALL ignore in_data/in_last while in S_OUT (in_ready=0).
REQ-024 SHALL treat in_last on the first beat as a one-term packet (out_count=1, out_data=in_data).
REQ-025 SHALL when MAXLEN is reached without in_last terminate the packet with out_count=MAXLEN; the next beat starts a new packet.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge enter S_ACC, with acc=0, count=0 and overflow=0.
REQ-027 SHALL drive in_ready=1, out_valid=0, out_data=0, out_count=0 and out_overflow=0 in the cycle following reset.
REQ-028 SHALL on reset mid-packet or mid-S_OUT discard the partial or pending result without emitting it.

Configuration
REQ-029 SHALL, with FXP_ACC_SATURATE_EN defined, clamp each overflowing step to 2^(WIDTH-1)-1 or -2^(WIDTH-1) by sign.
REQ-030 SHALL, without FXP_ACC_SATURATE_EN, wrap each step modulo 2^WIDTH; out_overflow behaves identically in both builds.

Structure
REQ-031 SHALL place the state enum, the Q-format width check helper and the saturation bounds function in package fxp_pkg.
REQ-032 SHALL instantiate one sub-module fxp_sat_add: combinational WIDTH-bit add returning sum and overflow, honouring FXP_ACC_SATURATE_EN.
REQ-033 SHALL flag an elaboration error unless WIDTH == INTEGERWIDTH + FRACTIONWIDTH and MAXLEN >= 1.

Verification
REQ-034 SHALL cover: beats 0x18 (1.5), then 0x24 (2.25) with last -> out_data=0x3C, out_count=2, out_overflow=0, out_valid one cycle after the last beat.
REQ-035 SHALL cover: 0x70 (7.0), then 0x20 (2.0) with last -> out_data=0x7F with the macro and 0x90 without; out_overflow=1 in both builds.
REQ-036 SHALL cover: 0x80 (-8.0), then 0xFF (-0.0625) with last -> out_data=0x80 with the macro, out_overflow=1.
REQ-037 SHALL cover: out_ready held low 5 cycles -> out_data stable, in_ready=0 and in_valid ignored; accept -> in_ready=1 the next cycle.
REQ-038 SHALL cover: 16 beats of 0x01 with no last -> out_data=0x10, out_count=16; the 17th beat starts a new packet.
REQ-039 SHALL cover: rst_n low for one cycle after 3 beats -> no output; a following 0x05-with-last packet -> out_data=0x05, out_count=1.
